tdm_demux: RTL and testbench

- Serial time-division demultiplexer: the receive end of the team's TDM mux link.
- Takes a serial bit stream framed by a frame-sync pulse and splits it into NUM_CH channel words of WIDTH bits.
- Each word goes to its own output register, with a per-channel valid strobe.
- Sits after the TDM serializer/link and feeds the per-channel parallel logic.

---
 rtl/tdm_demux.sv | 133 +++++++++++++
 tb/tb_tdm_demux.sv | 127 ++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: receive end of the TDM link. Assembles MSB-first
// slot words from a frame-synced bit stream. Each word goes to its own channel
// register, which raises a one-cycle valid strobe when it updates.

// Per-channel word register with a single-cycle update strobe.
module tdm_demux_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Capture the completed slot word; valid follows the load by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= ld;
      if (ld) data <= word;
    end
  end

endmodule

module tdm_demux #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_en,
  input  logic                    sdi,
  input  logic                    fs,
  output logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic                    frame_valid,
  output logic                    sync_err,
  output logic                    locked
);

  localparam int SW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int BW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_CH - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [SW-1:0]    slot;
  logic [BW-1:0]    bitc;
  logic [WIDTH-2:0] sr;     // the bits of the current slot received so far
  logic [WIDTH-1:0] word;
  logic             at_start;
  logic             slot_done;
  logic [NUM_CH-1:0] ld;

  // The word completing on this edge includes the bit being sampled now.
  assign word     = {sr, sdi};
  assign at_start = (slot == '0) && (bitc == '0);
  // fs on a slot's last bit is an early sync, so that partial slot is dropped.
  assign slot_done = bit_en && (state == RUN) && !fs && (bitc == BIT_LAST);
  assign locked    = (state == RUN);

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      assign ld[k] = slot_done && (slot == SW'(k));
      tdm_demux_ch #(.WIDTH(WIDTH)) u_ch (
        .clk   (clk),
        .rst   (rst),
        .ld    (ld[k]),
        .word  (word),
        .data  (ch_data[k*WIDTH +: WIDTH]),
        .valid (ch_valid[k])
      );
    end
  endgenerate

  // Framing FSM: hunt for fs, track slot/bit position, and flag sync violations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= '0;
      bitc        <= '0;
      sr          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (bit_en) begin
        sr <= word[WIDTH-2:0];
        if (state == HUNT) begin
          if (fs) begin
            state <= RUN;
            slot  <= '0;
            bitc  <= BW'(1);
          end
        end else if (at_start) begin
          // A frame boundary must carry fs; without it we have lost alignment.
          if (fs) begin
            bitc <= BW'(1);
          end else begin
            sync_err <= 1'b1;
            state    <= HUNT;
          end
        end else if (fs) begin
          // Early fs: drop the partial slot and restart at slot 0 bit 0.
          sync_err <= 1'b1;
          slot     <= '0;
          bitc     <= BW'(1);
        end else if (bitc == BIT_LAST) begin
          bitc <= '0;
          if (slot == SLOT_LAST) begin
            slot        <= '0;
            frame_valid <= 1'b1;
          end else begin
            slot <= slot + SW'(1);
          end
        end else begin
          bitc <= bitc + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NUM_CH=4, WIDTH=8).
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bit_en = 1'b0;
  logic        sdi = 1'b0;
  logic        fs = 1'b0;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_valid, sync_err, locked;

  int checks = 0;
  int failures = 0;
  int gap = 0;

  tdm_demux #(.NUM_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sdi(sdi), .fs(fs),
    .ch_data(ch_data), .ch_valid(ch_valid), .frame_valid(frame_valid),
    .sync_err(sync_err), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Optional idle cycles (bit_en=0) then one sampled bit; returns #1 after the edge.
  task automatic send_bit(input logic b, input logic f);
    for (int g = 0; g < gap; g++) begin
      bit_en = 1'b0;
      @(posedge clk); #1;
      chk("idle_pulses", {29'd0, ch_valid == 4'd0, !frame_valid, !sync_err}, 32'h7);
    end
    bit_en = 1'b1; sdi = b; fs = f;
    @(posedge clk); #1;
    fs = 1'b0;
  endtask

  // One frame, slot k = w[k*8 +: 8], fs on the first bit.
  task automatic send_frame(input logic [31:0] w, input logic exp_err);
    logic [31:0] prev;
    logic [7:0]  byt;
    prev = ch_data;
    for (int k = 0; k < 4; k++) begin
      byt = w[k*8 +: 8];
      for (int i = 7; i >= 0; i--) begin
        send_bit(byt[i], (k == 0) && (i == 7));
        if (i == 7) chk("valid_clear_slot_start", {28'd0, ch_valid}, 32'd0);
        if (k == 0 && i == 7) begin
          chk("fs_sync_err", {31'd0, sync_err}, {31'd0, exp_err});
          chk("fs_locked", {31'd0, locked}, 32'd1);
          chk("fs_data_hold", ch_data, prev);
        end
        if (k == 0 && i == 6) chk("sync_err_1cyc", {31'd0, sync_err}, 32'd0);
        if (i == 0) begin
          chk("slot_valid", {28'd0, ch_valid}, 32'd1 << k);
          chk("frame_valid", {31'd0, frame_valid}, (k == 3) ? 32'd1 : 32'd0);
          chk("slot_sync_err", {31'd0, sync_err}, 32'd0);
        end
      end
    end
    chk("frame_data", ch_data, w);
  endtask

  initial begin
    // Reset
    #2 rst = 1'b1;
    #20;
    chk("rst_data", ch_data, 32'd0);
    chk("rst_pulses", {28'd0, ch_valid}, 32'd0);
    chk("rst_flags", {29'd0, frame_valid, sync_err, locked}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Leading bits with no fs are discarded in HUNT
    for (int i = 0; i < 10; i++) begin
      send_bit(i[0], 1'b0);
      chk("hunt_flags", {30'd0, sync_err, locked}, 32'd0);
    end
    send_frame(32'hF00F3CA5, 1'b0);

    // Back-to-back frames with no gap bit
    send_frame(32'h44332211, 1'b0);
    chk("b2b_locked", {31'd0, locked}, 32'd1);
    send_frame(32'h88776655, 1'b0);

    // Early fs at slot 1 bit 3: slot 0 completes, slot 1 partial is dropped
    for (int i = 7; i >= 0; i--) send_bit(i[0], i == 7);
    chk("early_slot0", ch_data, 32'h887766AA);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_frame(32'hF00F3CA5, 1'b1);

    // Missing fs at frame boundary
    send_bit(1'b1, 1'b0);
    chk("bnd_sync_err", {31'd0, sync_err}, 32'd1);
    chk("bnd_unlocked", {31'd0, locked}, 32'd0);
    send_bit(1'b0, 1'b0);
    chk("bnd_err_1cyc", {31'd0, sync_err}, 32'd0);
    chk("bnd_still_hunt", {31'd0, locked}, 32'd0);
    send_frame(32'hEFBEADDE, 1'b0);

    // bit_en every 3rd cycle
    gap = 2;
    send_frame(32'h6996C35A, 1'b0);

    // Async reset in the middle of slot 2
    for (int i = 0; i < 19; i++) send_bit(i[1], i == 0);
    chk("pre_rst_locked", {31'd0, locked}, 32'd1);
    bit_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data", ch_data, 32'd0);
    chk("mid_rst_flags", {25'd0, ch_valid, frame_valid, sync_err, locked}, 32'd0);
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
